main_fsm: RTL

Moore state machine at the heart of the multicycle controller. It sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives the datapath enables and mux selects for every cycle. The 2-bit `ResultSrc` and `ALUSrcB` selects it produces feed the datapath's 3:1 result and ALU-operand multiplexers directly. Condition checking, ALU decode and PC-write gating stay in the surrounding controller.

---
 rtl/main_fsm.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - Moore sequencer for the multicycle controller; optional sticky trap via MAIN_FSM_TRAP_EN
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       Trap,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  state_t state_q;
  state_t state_d;

  // Only the I and L flags steer sequencing; the middle Funct bits belong to the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State register with synchronous active-low reset back to FETCH.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; instruction fields are only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
`ifdef MAIN_FSM_TRAP_EN
      UNKNOWN:  state_d = UNKNOWN;
`else
      UNKNOWN:  state_d = FETCH;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // Moore output decode; every field defaults to 0 so unused encodings drive nothing.
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    Trap      = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcB   = 2'b01;
      end
      MEMRD: begin
        AdrSrc    = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        MemW      = 1'b1;
      end
      EXECUTER: begin
        ALUOp     = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB   = 2'b01;
        ALUOp     = 1'b1;
      end
      ALUWB: begin
        RegW      = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      UNKNOWN: begin
`ifdef MAIN_FSM_TRAP_EN
        Trap      = 1'b1;
`else
        Trap      = 1'b0;
`endif
      end
      default: begin
        IRWrite   = 1'b0;
      end
    endcase
  end

  assign State = state_q;

endmodule
